ball_motion_ctrl: RTL and testbench
===================================

Name: ball_motion_ctrl

Overview:
- Per-frame position controller for the on-screen ball.
- Detects each vsync rising edge and latches the four direction buttons. Over a short sequenced computation it produces a new clamped ball position, then commits it with a one-cycle strobe.
- Sits between the button inputs / video_sync_generator and the ball renderer, which consumes o_ball_x/o_ball_y as absolute coordinates.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- BALL_SIZE, 8, ball width and height in pixels.
- STEP, 2, base pixels moved per frame per pressed axis.
- START_X, 316, reset X (top-left corner of the ball).
- START_Y, 236, reset Y.

Ports:
- i_clk  in  1  system/pixel clock.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_vsync  in  1  vertical sync from video_sync_generator; level, active-high.
- i_up  in  1  button; level, active-high. Same for i_down, i_left, i_right.
- o_ball_x  out  10  committed ball X, range 0..H_ACTIVE-BALL_SIZE.
- o_ball_y  out  10  committed ball Y, range 0..V_ACTIVE-BALL_SIZE.
- o_update  out  1  one-cycle pulse when a new position is committed.
- o_busy  out  1  high while not in IDLE.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values:
  - o_ball_x=START_X, o_ball_y=START_Y.
  - o_update=0, o_busy=0.
  - State IDLE; vsync delay register=0; latched buttons=0; internal next-position registers = START values.
- Edge detect: r_vsync_d <= i_vsync every cycle. A frame event is i_vsync=1 && r_vsync_d=0.
- FSM states: IDLE, MOVE_X, MOVE_Y, COMMIT.
  - IDLE: on a frame event, latch {up,down,left,right} and go to MOVE_X. Otherwise stay.
  - MOVE_X: compute r_next_x from o_ball_x and the latched left/right, then go to MOVE_Y.
  - MOVE_Y: compute r_next_y from o_ball_y and the latched up/down, then go to COMMIT.
  - COMMIT: o_ball_x<=r_next_x, o_ball_y<=r_next_y, o_update<=1, then go to IDLE.
- Latency: with the frame event sampled at edge N, outputs change and o_update is high for exactly the cycle after edge N+3.
- o_busy: high in MOVE_X, MOVE_Y and COMMIT.
- Axis step rule (same for both axes; "neg" = left/up, "pos" = right/down):
  - Arithmetic is done in 11 bits unsigned; no wrap-around allowed.
  - neg only: next = (cur < step) ? 0 : cur - step.
  - pos only: next = (cur + step > MAX) ? MAX : cur + step, where MAX = ACTIVE-BALL_SIZE.
  - Both or neither pressed: next = cur.
- Buttons are sampled only at the frame event. Changes during MOVE_X..COMMIT are ignored.
- A frame event while not in IDLE is dropped; there is no queueing.
- o_update deasserts the cycle after COMMIT.
- Reset mid-operation: all registers return immediately to reset values. The partial computation is discarded and o_update is never issued for it.
- i_vsync held high: only one event, since the edge is required.

Optional Feature:
- Macro BALL_MOTION_ACCEL_EN.
- Defined:
  - Each axis has a 2-bit speed register, reset 0, giving multiplier = speed+1 and step = STEP*(speed+1).
  - Speed increments (saturating at 3) after each commit in which that axis moved in the same direction as the previous commit.
  - Speed clears to 0 when the axis is idle, both buttons are pressed, or the direction reverses.
  - Hitting a clamp does not clear speed.
  - The previous direction is also reset to none.
- Undefined: step is always STEP; the speed registers do not exist.

Decomposition:
- Shared package ball_pkg:
  - H_ACTIVE/V_ACTIVE/BALL_SIZE defaults.
  - MAX_X/MAX_Y derived constants.
  - FSM state typedef (2-bit enum: IDLE, MOVE_X, MOVE_Y, COMMIT).
- One sub-module, ball_axis_step: a combinational clamp-step (cur, neg, pos, step, max -> next), instantiated once per axis.
- The accel speed registers stay in the top.

Test Plan:
- Reset: hold i_rst_n=0, release -> o_ball_x=316, o_ball_y=236, o_update=0, o_busy=0. Toggling i_vsync with no buttons pressed -> o_update pulses each frame, position unchanged.
- Right held, one vsync rise -> o_busy high for 3 cycles. o_update pulses exactly 4 cycles after the sampling edge; x=318, y=236.
- Clamp low: drive to x=1, left held, one frame -> x=0. Next frame -> x=0, no underflow to 1023.
- Clamp high: y=471, down held -> y=472. Another frame -> y=472.
- Simultaneous up+down and left+right -> no change. Buttons pressed only during MOVE_X -> ignored. Second vsync rise during MOVE_Y -> no extra update.
- Async reset asserted in MOVE_Y -> outputs go to START values immediately, no o_update.
- With BALL_MOTION_ACCEL_EN, right held 5 frames from x=316 -> x=318, 322, 328, 336, 344. Release one frame -> speed cleared; next press moves +2.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared constants, FSM state type and small helpers for the ball motion controller.
// The BALL_MOTION_ACCEL_EN build uses dir_t and next_speed for per-axis acceleration.
package ball_pkg;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int BALL_SIZE_DEF = 8;
  localparam int MAX_X = H_ACTIVE_DEF - BALL_SIZE_DEF;
  localparam int MAX_Y = V_ACTIVE_DEF - BALL_SIZE_DEF;

  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, COMMIT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_NEG, DIR_POS} dir_t;

  function automatic dir_t axis_dir(input logic neg, input logic pos);
    if (neg && !pos) return DIR_NEG;
    if (pos && !neg) return DIR_POS;
    return DIR_NONE;
  endfunction

  // Speed grows only while the axis keeps moving the same way (starting from rest counts).
  function automatic logic [1:0] next_speed(input logic [1:0] speed, input dir_t prev, input dir_t cur);
    if (cur == DIR_NONE || (prev != DIR_NONE && prev != cur)) return 2'd0;
    return (speed == 2'd3) ? speed : speed + 2'd1;
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// Combinational clamp-step for one axis: move by step toward 0 or toward max, never wrapping.
module ball_axis_step (
  input  logic [10:0] cur,
  input  logic        neg,
  input  logic        pos,
  input  logic [10:0] step,
  input  logic [10:0] max,
  output logic [10:0] next
);

  always_comb begin
    next = cur;
    if (neg && !pos) begin
      next = (cur < step) ? 11'd0 : cur - step;
    end else if (pos && !neg) begin
      next = (cur + step > max) ? max : cur + step;
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball position controller: latch buttons on vsync rise, step X then Y, commit with a pulse.
// Optional per-axis acceleration is enabled by defining BALL_MOTION_ACCEL_EN.
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int BALL_SIZE = BALL_SIZE_DEF,
  parameter int STEP      = 2,
  parameter int START_X   = 316,
  parameter int START_Y   = 236
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_vsync,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  output logic [9:0] o_ball_x,
  output logic [9:0] o_ball_y,
  output logic       o_update,
  output logic       o_busy
);

  state_t            state_reg, state_next;
  logic              vsync_d_reg;
  logic [3:0]        btn_reg;           // {up, down, left, right}
  logic [1:0][10:0]  ball_reg;          // index 0 = X, 1 = Y
  logic [1:0][10:0]  next_reg;
  logic              update_reg;
  logic [10:0]       stepped [2];
  logic [1:0]        neg_w, pos_w;
  logic              frame_event;

  assign frame_event = i_vsync && !vsync_d_reg;
  assign neg_w = {btn_reg[3], btn_reg[1]};
  assign pos_w = {btn_reg[2], btn_reg[0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (frame_event) state_next = MOVE_X;
      MOVE_X:  state_next = MOVE_Y;
      MOVE_Y:  state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vsync_d_reg <= 1'b0;
      btn_reg     <= 4'd0;
      ball_reg    <= {11'(START_Y), 11'(START_X)};
      next_reg    <= {11'(START_Y), 11'(START_X)};
      update_reg  <= 1'b0;
    end else begin
      vsync_d_reg <= i_vsync;
      update_reg  <= 1'b0;
      case (state_reg)
        IDLE:    if (frame_event) btn_reg <= {i_up, i_down, i_left, i_right};
        MOVE_X:  next_reg[0] <= stepped[0];
        MOVE_Y:  next_reg[1] <= stepped[1];
        COMMIT: begin
          ball_reg   <= next_reg;
          update_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    localparam logic [10:0] LIMIT = (gi == 0) ? 11'(H_ACTIVE - BALL_SIZE) : 11'(V_ACTIVE - BALL_SIZE);
    logic [10:0] step;
`ifdef BALL_MOTION_ACCEL_EN
    logic [1:0] speed_reg;
    dir_t       dir_reg;

    // Speed used in MOVE_X/MOVE_Y is the one from before this commit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        speed_reg <= 2'd0;
        dir_reg   <= DIR_NONE;
      end else if (state_reg == COMMIT) begin
        speed_reg <= next_speed(speed_reg, dir_reg, axis_dir(neg_w[gi], pos_w[gi]));
        dir_reg   <= axis_dir(neg_w[gi], pos_w[gi]);
      end
    end

    assign step = 11'(STEP * (int'(speed_reg) + 1));
`else
    assign step = 11'(STEP);
`endif

    ball_axis_step u_step (
      .cur  (ball_reg[gi]),
      .neg  (neg_w[gi]),
      .pos  (pos_w[gi]),
      .step (step),
      .max  (LIMIT),
      .next (stepped[gi])
    );
  end

  assign o_ball_x = ball_reg[0][9:0];
  assign o_ball_y = ball_reg[1][9:0];
  assign o_update = update_reg;
  assign o_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench for ball_motion_ctrl: frames push expected positions, a monitor checks each o_update.
module tb_ball_motion_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_vsync = 1'b0;
  logic       i_up = 1'b0, i_down = 1'b0, i_left = 1'b0, i_right = 1'b0;
  logic [9:0] o_ball_x, o_ball_y;
  logic       o_update, o_busy;

  always #5 i_clk = ~i_clk;

  ball_motion_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vsync(i_vsync),
    .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right),
    .o_ball_x(o_ball_x), .o_ball_y(o_ball_y), .o_update(o_update), .o_busy(o_busy)
  );

  typedef struct {int x; int y;} exp_t;
  exp_t exp_q[$];

  int n_vec = 0, n_err = 0, upd_cnt = 0;
  int mx = 316, my = 236, sx = 0, sy = 0, dx = 0, dy = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Expected-value model of one axis move.
  function automatic int step_axis(input int cur, input logic neg, input logic pos, input int max, input int spd);
    int st;
`ifdef BALL_MOTION_ACCEL_EN
    st = 2 * (spd + 1);
`else
    st = 2 + 0 * spd;
`endif
    if (neg && !pos) return (cur < st) ? 0 : cur - st;
    if (pos && !neg) return (cur + st > max) ? max : cur + st;
    return cur;
  endfunction

  task automatic model_speed(inout int spd, inout int dir, input logic neg, input logic pos);
    int d;
    d = (neg && !pos) ? -1 : ((pos && !neg) ? 1 : 0);
    if (d == 0 || (dir != 0 && dir != d)) spd = 0;
    else if (spd < 3) spd = spd + 1;
    dir = d;
  endtask

  task automatic model_reset();
    mx = 316; my = 236; sx = 0; sy = 0; dx = 0; dy = 0;
  endtask

  task automatic expect_frame(input logic u, input logic d, input logic l, input logic r);
    int ex, ey;
    ex = step_axis(mx, l, r, 632, sx);
    ey = step_axis(my, u, d, 472, sy);
    model_speed(sx, dx, l, r);
    model_speed(sy, dy, u, d);
    mx = ex; my = ey;
    exp_q.push_back('{ex, ey});
  endtask

  task automatic wait_update(input int start);
    int k = 0;
    while (upd_cnt == start && k < 12) begin
      @(negedge i_clk); #1;
      k++;
    end
    if (upd_cnt == start) begin
      check("update_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic frame(input logic u, input logic d, input logic l, input logic r);
    int start;
    @(posedge i_clk); #1;
    {i_up, i_down, i_left, i_right} = {u, d, l, r};
    i_vsync = 1'b1;
    expect_frame(u, d, l, r);
    start = upd_cnt;
    @(posedge i_clk); #1;
    i_vsync = 1'b0;
    {i_up, i_down, i_left, i_right} = 4'b0000;
    wait_update(start);
  endtask

  // Monitor: every update must match the oldest outstanding expectation.
  always @(negedge i_clk) begin : monitor
    exp_t e;
    if (o_update) begin
      upd_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_update", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("update_x", int'(o_ball_x), e.x);
        check("update_y", int'(o_ball_y), e.y);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int start;
    int busy_exp [5] = '{1, 1, 1, 0, 0};
    int upd_exp  [5] = '{0, 0, 0, 1, 0};
    int accel_tbl [5];
`ifdef BALL_MOTION_ACCEL_EN
    accel_tbl = '{318, 322, 328, 336, 344};
`else
    accel_tbl = '{318, 320, 322, 324, 326};
`endif

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_x", int'(o_ball_x), 316);
    check("reset_y", int'(o_ball_y), 236);
    check("reset_update", int'(o_update), 0);
    check("reset_busy", int'(o_busy), 0);
    @(posedge i_clk); #1 i_rst_n = 1'b1;

    // Idle frames: pulse each frame, no movement
    frame(0, 0, 0, 0);
    frame(0, 0, 0, 0);
    check("idle_x", int'(o_ball_x), 316);
    check("idle_y", int'(o_ball_y), 236);

    // Right held: busy for 3 cycles, update on the 4th
    @(posedge i_clk); #1;
    i_right = 1'b1; i_vsync = 1'b1;
    expect_frame(0, 0, 0, 1);
    @(posedge i_clk); #1;
    i_vsync = 1'b0; i_right = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check($sformatf("latency_busy_%0d", k), int'(o_busy), busy_exp[k]);
      check($sformatf("latency_update_%0d", k), int'(o_update), upd_exp[k]);
    end
    check("right_x", int'(o_ball_x), 318);
    check("right_y", int'(o_ball_y), 236);

    // Opposing buttons cancel
    frame(0, 0, 1, 1);
    frame(1, 1, 0, 0);
    frame(1, 1, 1, 1);
    check("opposed_x", int'(o_ball_x), 318);
    check("opposed_y", int'(o_ball_y), 236);

    // Buttons pressed only after the sampling edge are ignored
    @(posedge i_clk); #1;
    i_vsync = 1'b1;
    expect_frame(0, 0, 0, 0);
    start = upd_cnt;
    @(posedge i_clk); #1;
    i_vsync = 1'b0; i_right = 1'b1; i_down = 1'b1;
    wait_update(start);
    i_right = 1'b0; i_down = 1'b0;
    check("late_button_x", int'(o_ball_x), 318);
    check("late_button_y", int'(o_ball_y), 236);

    // Second vsync rise during MOVE_Y is dropped; held-high vsync gives one event
    @(posedge i_clk); #1;
    i_vsync = 1'b1; i_right = 1'b1;
    expect_frame(0, 0, 0, 1);
    start = upd_cnt;
    @(posedge i_clk); #1;
    i_vsync = 1'b0;
    @(posedge i_clk); #1;
    i_vsync = 1'b1;
    repeat (15) @(posedge i_clk);
    #1;
    check("double_edge_updates", upd_cnt - start, 1);
    check("double_edge_x", int'(o_ball_x), 320);
    i_vsync = 1'b0; i_right = 1'b0;

    // Clamp low on X
    for (int k = 0; k < 162; k++) frame(0, 0, 1, 0);
    check("clamp_low_x", int'(o_ball_x), 0);
    frame(0, 0, 1, 0);
    check("clamp_low_hold_x", int'(o_ball_x), 0);

    // Clamp high on Y
    for (int k = 0; k < 120; k++) frame(0, 1, 0, 0);
    check("clamp_high_y", int'(o_ball_y), 472);
    frame(0, 1, 0, 0);
    check("clamp_high_hold_y", int'(o_ball_y), 472);

    // Asynchronous reset while in MOVE_Y: immediate START values, no update
    @(posedge i_clk); #1;
    i_vsync = 1'b1; i_right = 1'b1;
    @(posedge i_clk); #1;
    i_vsync = 1'b0; i_right = 1'b0;
    @(posedge i_clk); #2;
    check("pre_reset_busy", int'(o_busy), 1);
    i_rst_n = 1'b0;
    #1;
    check("async_reset_x", int'(o_ball_x), 316);
    check("async_reset_y", int'(o_ball_y), 236);
    check("async_reset_busy", int'(o_busy), 0);
    start = upd_cnt;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    model_reset();
    repeat (6) @(posedge i_clk);
    #1;
    check("no_update_after_reset", upd_cnt - start, 0);

    // Repeated right presses (accelerating when the feature is built in)
    for (int k = 0; k < 5; k++) begin
      frame(0, 0, 0, 1);
      check($sformatf("run_right_%0d", k), int'(o_ball_x), accel_tbl[k]);
    end
    frame(0, 0, 0, 0);
    check("release_x", int'(o_ball_x), accel_tbl[4]);
    frame(0, 0, 0, 1);
    check("repress_x", int'(o_ball_x), accel_tbl[4] + 2);

    repeat (4) @(posedge i_clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
